lsd_frame_pingpong_buffer: RTL and testbench
============================================

// Module: lsd_frame_pingpong_buffer
// PURPOSE
//   Multi-channel, double-buffered store for LSD line segments. Each camera channel writes
//   segments into its fill bank during a frame. At frame end the banks swap, and the
//   completed frame is published to the PS read side with a line count and an overflow flag.
//   It replaces the per-camera single-bank output buffers, sitting between simple_lsd and pspl_comm.
// PARAMETERS
//   NUM_CH   2    number of camera channels (>=1)
//   H_BITW   10   horizontal coordinate width
//   V_BITW   9    vertical coordinate width
//   DEPTH    256  segments stored per bank per channel (power of 2, >=4)
//   derived: AW=$clog2(DEPTH), CW=$clog2(DEPTH+1), SW=2*(V_BITW+H_BITW), CHW=max(1,$clog2(NUM_CH))
// PORTS
//   clock          in   1            single clock (clk_12m domain)
//   rst            in   1            reset: asynchronous, active-high
//   in_flag        in   NUM_CH       per-channel frame-active level from LSD
//   in_valid       in   NUM_CH       per-channel segment strobe
//   in_start_v     in   NUM_CH*V_BITW  segment start row, channel c at [c*V_BITW +: V_BITW]
//   in_start_h     in   NUM_CH*H_BITW  segment start column
//   in_end_v       in   NUM_CH*V_BITW  segment end row
//   in_end_h       in   NUM_CH*H_BITW  segment end column
//   rd_ch          in   CHW          channel selected for reading
//   rd_addr        in   AW           segment index within the published bank
//   rd_ack         in   NUM_CH       pulse: PS finished reading the channel, release the bank
//   out_ready      out  NUM_CH       published bank holds an unread frame
//   out_line_num   out  NUM_CH*CW    segment count of the published frame
//   out_overflow   out  NUM_CH       published frame lost segments (count hit DEPTH)
//   out_drop_cnt   out  NUM_CH*16    frames discarded because the bank was still held (saturating)
//   out_data       out  SW           {start_v,start_h,end_v,end_h} at rd_ch/rd_addr
// BEHAVIOUR
//   Reset (async, rst=1)
//     - all outputs 0; fill counts 0; fill bank = bank0 for every channel.
//     - prev-flag registers 0. Memory contents are don't-care.
//   Frame end for channel c: detected on the cycle flag_d[c]=1 and in_flag[c]=0 (falling edge).
//   Write, per channel
//     - in_valid[c]=1 and fill_cnt<DEPTH: store at fill bank[fill_cnt], then fill_cnt++.
//     - in_valid[c]=1 and fill_cnt==DEPTH: write dropped, sticky ovf_fill[c] set.
//     - A valid on the frame-end cycle belongs to the ending frame.
//       Its write and count are included in the published count.
//   Per-channel FSM, states IDLE (no published frame) and HELD (out_ready=1)
//     - Frame end in IDLE:
//         - swap banks; out_line_num <= final count (incl. same-cycle write);
//         - out_overflow <= final ovf; out_ready <= 1 on the next cycle; go to HELD.
//     - Frame end in HELD:
//         - no swap; fill bank reused from index 0;
//         - out_drop_cnt++ (saturate at 16'hFFFF); published outputs unchanged.
//     - rd_ack[c] in HELD: out_ready <= 0, go to IDLE. rd_ack in IDLE is ignored.
//     - rd_ack and frame end on the same cycle: ack applies first, then the swap proceeds.
//       Net result: HELD with the new frame, no drop counted.
//     - Every frame end clears fill_cnt and ovf_fill for the next frame.
//   Read
//     - out_data is registered, with latency 1 cycle from rd_ch/rd_addr.
//     - Source is the published (non-fill) bank of channel rd_ch.
//     - rd_addr >= out_line_num[rd_ch], or rd_ch >= NUM_CH: out_data = 0.
//     - The read value is only defined while out_ready[rd_ch]=1.
//   Channels are fully independent; simultaneous events on different channels never interact.
//   Reset mid-frame: the partial frame is discarded and no publication occurs.
//   A flag already high at reset release starts a frame with no frame-end side effects.
// TESTING
//   T1 ch0: flag high, 5 valids, flag low
//      -> next cycle out_ready=01, line_num[0]=5, overflow=0.
//      -> reading addr 0..4 returns the written data at 1-cycle latency; addr 5 returns 0.
//   T2 ch1: DEPTH+3 valids in one frame
//      -> line_num[1]=DEPTH, overflow[1]=1, and entry DEPTH-1 is the DEPTH-th segment.
//   T3 ch0 held, second frame of 7 segments ends without rd_ack
//      -> drop_cnt[0]=1, line_num[0] stays 5.
//      -> after rd_ack, a third frame of 2 segments publishes line_num=2.
//   T4 rd_ack[0] and the ch0 frame end (3 segments) on the same cycle
//      -> out_ready[0]=1, line_num[0]=3, drop_cnt unchanged.
//   T5 both channels end frames in the same cycle with 4 and 9 segments
//      -> out_ready=11, line_num={9,4}, and the read data is not crossed between channels.
//   T6 rst pulse mid-frame after 3 valids
//      -> all outputs 0 asynchronously; the next full frame of 2 segments publishes line_num=2.

Source files
------------

// File: rtl/lsd_frame_pingpong_buffer.sv
// Multi-channel double-buffered LSD segment store: each channel fills one bank per frame,
// and at frame end the banks swap and the finished frame is published to the PS read side.
module lsd_frame_pingpong_buffer #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned H_BITW = 10,
    parameter int unsigned V_BITW = 9,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned CW     = $clog2(DEPTH + 1),
    parameter int unsigned SW     = 2 * (V_BITW + H_BITW),
    parameter int unsigned CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_flag,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*V_BITW-1:0] in_start_v,
    input  logic [NUM_CH*H_BITW-1:0] in_start_h,
    input  logic [NUM_CH*V_BITW-1:0] in_end_v,
    input  logic [NUM_CH*H_BITW-1:0] in_end_h,
    input  logic [CHW-1:0]           rd_ch,
    input  logic [AW-1:0]            rd_addr,
    input  logic [NUM_CH-1:0]        rd_ack,
    output logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*CW-1:0]     out_line_num,
    output logic [NUM_CH-1:0]        out_overflow,
    output logic [NUM_CH*16-1:0]     out_drop_cnt,
    output logic [SW-1:0]            out_data
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HELD = 1'b1
    } state_t;

    logic [SW-1:0] w_rd_word [NUM_CH];
    logic [SW-1:0] w_rd_sel;
    logic [SW-1:0] r_out_data;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t        r_state;
        state_t        w_state_nxt;
        logic          r_flag_d;
        logic          r_fill_bank;
        logic          r_ovf_fill;
        logic [CW-1:0] r_fill_cnt;
        logic [CW-1:0] r_line_num;
        logic          r_overflow;
        logic [15:0]   r_drop_cnt;
        logic [SW-1:0] r_mem [2*DEPTH];

        logic          w_fend;
        logic          w_full;
        logic          w_wr;
        logic [CW-1:0] w_cnt_final;
        logic          w_ovf_final;
        logic          w_publish;
        logic          w_drop;
        logic [SW-1:0] w_seg;

        // Fill-side status, including a write landing on the frame-end cycle
        always_comb begin
            w_seg       = {in_start_v[c*V_BITW +: V_BITW], in_start_h[c*H_BITW +: H_BITW],
                           in_end_v[c*V_BITW +: V_BITW],   in_end_h[c*H_BITW +: H_BITW]};
            w_fend      = r_flag_d & ~in_flag[c];
            w_full      = (r_fill_cnt == CW'(DEPTH));
            w_wr        = in_valid[c] & ~w_full;
            w_cnt_final = w_wr ? r_fill_cnt + CW'(1) : r_fill_cnt;
            w_ovf_final = r_ovf_fill | (in_valid[c] & w_full);
        end

        always_ff @(posedge clock or posedge rst) begin
            if (rst) begin
                r_state <= S_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // An ack coinciding with frame end frees the bank before the swap is decided
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                S_IDLE: if (w_fend) w_state_nxt = S_HELD;
                S_HELD: if (rd_ack[c] && !w_fend) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end

        always_comb begin
            w_publish = 1'b0;
            w_drop    = 1'b0;
            case (r_state)
                S_IDLE: w_publish = w_fend;
                S_HELD: begin
                    w_publish = w_fend & rd_ack[c];
                    w_drop    = w_fend & ~rd_ack[c];
                end
                default: ;
            endcase
        end

        always_ff @(posedge clock or posedge rst) begin
            if (rst) begin
                r_flag_d    <= 1'b0;
                r_fill_bank <= 1'b0;
                r_ovf_fill  <= 1'b0;
                r_fill_cnt  <= '0;
                r_line_num  <= '0;
                r_overflow  <= 1'b0;
                r_drop_cnt  <= '0;
            end else begin
                r_flag_d <= in_flag[c];
                if (w_fend) begin
                    r_fill_cnt <= '0;
                    r_ovf_fill <= 1'b0;
                end else begin
                    r_fill_cnt <= w_cnt_final;
                    r_ovf_fill <= w_ovf_final;
                end
                if (w_publish) begin
                    r_fill_bank <= ~r_fill_bank;
                    r_line_num  <= w_cnt_final;
                    r_overflow  <= w_ovf_final;
                end
                if (w_drop && r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end

        // Segment storage; contents need no reset
        always_ff @(posedge clock) begin
            if (w_wr) begin
                r_mem[{r_fill_bank, r_fill_cnt[AW-1:0]}] <= w_seg;
            end
        end

        always_comb begin
            w_rd_word[c] = '0;
            if (CW'(rd_addr) < r_line_num) begin
                w_rd_word[c] = r_mem[{~r_fill_bank, rd_addr}];
            end
        end

        assign out_ready[c]               = (r_state == S_HELD);
        assign out_line_num[c*CW +: CW]   = r_line_num;
        assign out_overflow[c]            = r_overflow;
        assign out_drop_cnt[c*16 +: 16]   = r_drop_cnt;
    end

    // Unmatched channel selects fall through to zero
    always_comb begin
        w_rd_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CHW'(c)) begin
                w_rd_sel = w_rd_word[c];
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
        end else begin
            r_out_data <= w_rd_sel;
        end
    end

    assign out_data = r_out_data;

endmodule

// File: tb/tb_lsd_frame_pingpong_buffer.sv
// Bench for lsd_frame_pingpong_buffer: directed frame scenarios plus random traffic,
// checked every cycle against a queue-based frame model.
module tb_lsd_frame_pingpong_buffer;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned H_BITW = 10;
    localparam int unsigned V_BITW = 9;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned AW     = 8;
    localparam int unsigned CW     = 9;
    localparam int unsigned SW     = 38;
    localparam int unsigned CHW    = 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        in_flag;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*V_BITW-1:0] in_start_v;
    logic [NUM_CH*H_BITW-1:0] in_start_h;
    logic [NUM_CH*V_BITW-1:0] in_end_v;
    logic [NUM_CH*H_BITW-1:0] in_end_h;
    logic [CHW-1:0]           rd_ch;
    logic [AW-1:0]            rd_addr;
    logic [NUM_CH-1:0]        rd_ack;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*CW-1:0]     out_line_num;
    logic [NUM_CH-1:0]        out_overflow;
    logic [NUM_CH*16-1:0]     out_drop_cnt;
    logic [SW-1:0]            out_data;

    lsd_frame_pingpong_buffer #(
        .NUM_CH(NUM_CH), .H_BITW(H_BITW), .V_BITW(V_BITW), .DEPTH(DEPTH)
    ) u_dut (
        .clock       (clk),
        .rst         (rst),
        .in_flag     (in_flag),
        .in_valid    (in_valid),
        .in_start_v  (in_start_v),
        .in_start_h  (in_start_h),
        .in_end_v    (in_end_v),
        .in_end_h    (in_end_h),
        .rd_ch       (rd_ch),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .out_ready   (out_ready),
        .out_line_num(out_line_num),
        .out_overflow(out_overflow),
        .out_drop_cnt(out_drop_cnt),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference: segments of the open frame and of the published frame
    logic [SW-1:0] m_frame [NUM_CH][$];
    logic [SW-1:0] m_pub   [NUM_CH][$];
    bit            m_fd    [NUM_CH];
    bit            m_ovf   [NUM_CH];
    bit            m_held  [NUM_CH];
    bit            m_povf  [NUM_CH];
    int            m_line  [NUM_CH];
    int            m_drop  [NUM_CH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_frame[c].delete();
            m_pub[c].delete();
            m_fd[c]   = 1'b0;
            m_ovf[c]  = 1'b0;
            m_held[c] = 1'b0;
            m_povf[c] = 1'b0;
            m_line[c] = 0;
            m_drop[c] = 0;
        end
    endfunction

    function automatic logic [SW-1:0] seg_of(input int c);
        return {in_start_v[c*V_BITW +: V_BITW], in_start_h[c*H_BITW +: H_BITW],
                in_end_v[c*V_BITW +: V_BITW],   in_end_h[c*H_BITW +: H_BITW]};
    endfunction

    function automatic void m_step();
        bit fe;
        for (int c = 0; c < NUM_CH; c++) begin
            fe = m_fd[c] && !in_flag[c];
            if (in_valid[c]) begin
                if (m_frame[c].size() < int'(DEPTH)) m_frame[c].push_back(seg_of(c));
                else m_ovf[c] = 1'b1;
            end
            if (fe) begin
                if (m_held[c] && !rd_ack[c]) begin
                    if (m_drop[c] < 65535) m_drop[c]++;
                end else begin
                    m_held[c] = 1'b1;
                    m_pub[c]  = m_frame[c];
                    m_line[c] = m_frame[c].size();
                    m_povf[c] = m_ovf[c];
                end
                m_frame[c].delete();
                m_ovf[c] = 1'b0;
            end else if (rd_ack[c]) begin
                m_held[c] = 1'b0;
            end
            m_fd[c] = in_flag[c];
        end
    endfunction

    task automatic check_all();
        logic [NUM_CH-1:0]    er;
        logic [NUM_CH-1:0]    eo;
        logic [NUM_CH*CW-1:0] el;
        logic [NUM_CH*16-1:0] ed;
        for (int c = 0; c < NUM_CH; c++) begin
            er[c]            = m_held[c];
            eo[c]            = m_povf[c];
            el[c*CW +: CW]   = CW'(m_line[c]);
            ed[c*16 +: 16]   = 16'(m_drop[c]);
        end
        chk("out_ready", out_ready, er);
        chk("out_line_num", out_line_num, el);
        chk("out_overflow", out_overflow, eo);
        chk("out_drop_cnt", out_drop_cnt, ed);
    endtask

    // One clock: model the edge, advance, then compare all outputs
    task automatic cyc();
        logic [SW-1:0] exp_rd;
        bit            rd_def;
        int            ch;
        int            a;
        ch     = int'(rd_ch);
        a      = int'(rd_addr);
        exp_rd = '0;
        rd_def = 1'b1;
        if (ch < NUM_CH && a < m_line[ch]) begin
            exp_rd = m_pub[ch][a];
            rd_def = m_held[ch];
        end
        m_step();
        @(posedge clk);
        #1;
        check_all();
        if (rd_def) chk("out_data", out_data, exp_rd);
        in_valid = '0;
        rd_ack   = '0;
    endtask

    task automatic drive_seg(input int c);
        in_valid[c]                   = 1'b1;
        in_start_v[c*V_BITW +: V_BITW] = V_BITW'($urandom);
        in_start_h[c*H_BITW +: H_BITW] = H_BITW'($urandom);
        in_end_v[c*V_BITW +: V_BITW]   = V_BITW'($urandom);
        in_end_h[c*H_BITW +: H_BITW]   = H_BITW'($urandom);
    endtask

    task automatic frame_segs(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            drive_seg(c);
            cyc();
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_flag    = '0;
        in_valid   = '0;
        in_start_v = '0;
        in_start_h = '0;
        in_end_v   = '0;
        in_end_h   = '0;
        rd_ch      = '0;
        rd_addr    = '0;
        rd_ack     = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("reset_data", out_data, '0);
        rst = 1'b0;
        cyc();

        // T1: ch0 frame of 5, then read back including one past the end
        in_flag[0] = 1'b1;
        cyc();
        frame_segs(0, 5);
        in_flag[0] = 1'b0;
        cyc();
        chk("t1_ready", out_ready, 2'b01);
        chk("t1_line0", out_line_num[CW-1:0], 64'd5);
        chk("t1_ovf0", out_overflow[0], 64'd0);
        rd_ch = 1'b0;
        for (int a = 0; a <= 5; a++) begin
            rd_addr = AW'(a);
            cyc();
        end
        chk("t1_rd_past_end", out_data, '0);

        // T2: ch1 overflow
        in_flag[1] = 1'b1;
        cyc();
        frame_segs(1, DEPTH + 3);
        in_flag[1] = 1'b0;
        cyc();
        chk("t2_line1", out_line_num[2*CW-1:CW], 64'(DEPTH));
        chk("t2_ovf1", out_overflow[1], 64'd1);
        rd_ch   = 1'b1;
        rd_addr = AW'(DEPTH - 1);
        cyc();

        // T3: ch0 still held, second frame dropped; after ack a third frame publishes
        in_flag[0] = 1'b1;
        cyc();
        frame_segs(0, 7);
        in_flag[0] = 1'b0;
        cyc();
        chk("t3_drop0", out_drop_cnt[15:0], 64'd1);
        chk("t3_line0", out_line_num[CW-1:0], 64'd5);
        rd_ack[0] = 1'b1;
        cyc();
        chk("t3_ack_ready0", out_ready[0], 64'd0);
        in_flag[0] = 1'b1;
        cyc();
        frame_segs(0, 2);
        in_flag[0] = 1'b0;
        cyc();
        chk("t3_line0_new", out_line_num[CW-1:0], 64'd2);

        // T4: ack and frame end together; last segment arrives on the frame-end cycle
        in_flag[0] = 1'b1;
        cyc();
        frame_segs(0, 2);
        in_flag[0] = 1'b0;
        drive_seg(0);
        rd_ack[0] = 1'b1;
        cyc();
        chk("t4_ready0", out_ready[0], 64'd1);
        chk("t4_line0", out_line_num[CW-1:0], 64'd3);
        chk("t4_drop0", out_drop_cnt[15:0], 64'd1);

        // T5: simultaneous frame ends on both channels
        rd_ack = 2'b11;
        cyc();
        in_flag = 2'b11;
        cyc();
        for (int i = 0; i < 9; i++) begin
            if (i < 4) drive_seg(0);
            drive_seg(1);
            cyc();
        end
        in_flag = 2'b00;
        cyc();
        chk("t5_ready", out_ready, 2'b11);
        chk("t5_line", out_line_num, {CW'(9), CW'(4)});
        for (int a = 0; a < 10; a++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ch   = CHW'(c);
                rd_addr = AW'(a);
                cyc();
            end
        end

        // T6: asynchronous reset mid-frame
        in_flag[0] = 1'b1;
        cyc();
        frame_segs(0, 3);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", out_ready, '0);
        chk("t6_rst_line", out_line_num, '0);
        chk("t6_rst_ovf", out_overflow, '0);
        chk("t6_rst_drop", out_drop_cnt, '0);
        chk("t6_rst_data", out_data, '0);
        m_reset();
        in_flag = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        in_flag[0] = 1'b1;
        cyc();
        frame_segs(0, 2);
        in_flag[0] = 1'b0;
        cyc();
        chk("t6_ready", out_ready, 2'b01);
        chk("t6_line0", out_line_num[CW-1:0], 64'd2);

        // Random traffic on both channels
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 15) == 0) in_flag[c] = ~in_flag[c];
                if ($urandom_range(0, 1) == 1) drive_seg(c);
                if ($urandom_range(0, 7) == 0) rd_ack[c] = 1'b1;
            end
            rd_ch   = CHW'($urandom_range(0, NUM_CH - 1));
            rd_addr = AW'($urandom_range(0, 15));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
